// File: rtl/alu_pipe.sv
// Registered 8-operation ALU with valid/ready handshake and sticky status flags.
// Define ALU_MUL_EN to make opcode 111 an iterative shift-add multiplier; otherwise it returns 0.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [2:0]       ALU_Control,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             sign_flag,
   output logic             overflow_flag,
   output logic             busy,
   output logic             dbg_state
);
   localparam int SHW = $clog2(WIDTH);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // the producer holds valid and its payload stable until that edge.
   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_ld;
   logic [WIDTH-1:0] w_ld_res;
   logic             w_ld_c;
   logic             w_ld_v;
   logic             w_ld_sf;
   logic             w_out_free;

   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic             r_zero;
   logic             r_carry;
   logic             r_sign;
   logic             r_ovf;

   assign w_out_free = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_shamt    = src_b[SHW-1:0];
   assign w_add      = {1'b0, src_a} + {1'b0, src_b};
   assign w_sub      = {1'b0, src_a} - {1'b0, src_b};
   // Bit WIDTH of the widened shift is the last bit pushed out of the result.
   assign w_shl      = {1'b0, src_a} << w_shamt;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (ALU_Control)
         3'b000: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_add[WIDTH-1] != src_a[WIDTH-1]);
         end
         3'b001: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_sub[WIDTH-1] != src_a[WIDTH-1]);
         end
         3'b010: w_res = src_a & src_b;
         3'b011: w_res = src_a | src_b;
         3'b100: w_res = src_a ^ src_b;
         3'b101: w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         3'b110: begin
            w_res = w_shl[WIDTH-1:0];
            w_c   = w_shl[WIDTH];
         end
         default: w_res = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;
   logic [SHW-1:0]     r_cnt;
   logic               r_mul_sf;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic               w_acc_mul;
   logic               w_mul_done;

   assign w_acc_mul  = w_accept && (ALU_Control == 3'b111);
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
   // The last shift-add step and the output load share one edge.
   assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = w_out_free;
            if (w_acc_mul) w_state_nxt = S_MUL;
         end
         S_MUL: begin
            busy = 1'b1;
            if (w_mul_done) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_mul_sf <= 1'b0;
      end else if (w_acc_mul) begin
         r_mcand  <= {{WIDTH{1'b0}}, src_a};
         r_mplier <= src_b;
         r_prod   <= '0;
         r_cnt    <= '0;
         r_mul_sf <= set_flags;
      end else if (r_state == S_MUL) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + SHW'(1);
      end
   end

   assign dbg_state = r_state;
   assign w_ld      = (w_accept && !w_acc_mul) || w_mul_done;
   assign w_ld_res  = w_mul_done ? w_prod_nxt[WIDTH-1:0] : w_res;
   assign w_ld_c    = w_mul_done ? |w_prod_nxt[2*WIDTH-1:WIDTH] : w_c;
   assign w_ld_v    = w_mul_done ? |w_prod_nxt[2*WIDTH-1:WIDTH] : w_v;
   assign w_ld_sf   = w_mul_done ? r_mul_sf : set_flags;
`else
   assign in_ready  = w_out_free;
   assign busy      = 1'b0;
   assign dbg_state = 1'b0;
   assign w_ld      = w_accept;
   assign w_ld_res  = w_res;
   assign w_ld_c    = w_c;
   assign w_ld_v    = w_v;
   assign w_ld_sf   = set_flags;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_sign      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_ld) begin
         r_out       <= w_ld_res;
         r_out_valid <= 1'b1;
         if (w_ld_sf) begin
            r_zero  <= (w_ld_res == '0);
            r_carry <= w_ld_c;
            r_sign  <= w_ld_res[WIDTH-1];
            r_ovf   <= w_ld_v;
         end
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign alu_out       = r_out;
   assign out_valid     = r_out_valid;
   assign zero_flag     = r_zero;
   assign carry_flag    = r_carry;
   assign sign_flag     = r_sign;
   assign overflow_flag = r_ovf;
endmodule
